// File: rtl/id_inst_queue_if.sv
// Handshake bundle between fetch (master side) and the ID-stage instruction queue.
// The master drives fetch entries, flush/kill and the decoder's consume strobe;
// the queue (slave side) returns its head entry, occupancy and stall hints.
interface id_inst_queue_if #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    parameter int EXC_W  = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              flush;
    logic              br_kill;
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc;
    logic [INST_W-1:0] in_inst;
    logic [EXC_W-1:0]  in_exc;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [INST_W-1:0] out_inst;
    logic [EXC_W-1:0]  out_exc;
    logic [CNT_W-1:0]  count;
    logic              afull;

    modport master (
        output flush, br_kill, in_valid, in_pc, in_inst, in_exc, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, out_exc, count, afull
    );

    modport slave (
        input  flush, br_kill, in_valid, in_pc, in_inst, in_exc, out_ready,
        output in_ready, out_valid, out_pc, out_inst, out_exc, count, afull
    );
endinterface

// File: rtl/id_inst_queue.sv
// ID-stage instruction queue: DEPTH-entry circular FIFO of {excepttype, pc, inst}
// between the i-cache return path and the decoder. Pointers carry an extra wrap
// bit so full and empty are distinguishable without a separate counter.
// flush and br_kill both empty the queue by snapping wr_ptr back to rd_ptr.
module id_inst_queue #(
    parameter int DEPTH     = 4,
    parameter int PC_W      = 32,
    parameter int INST_W    = 32,
    parameter int EXC_W     = 32,
    parameter int AFULL_LVL = DEPTH - 1
) (
    input logic             clk,
    input logic             rst,
    id_inst_queue_if.slave  q
);
    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = AW + 1;
    localparam int ENT_W = EXC_W + PC_W + INST_W;
    localparam logic [PW-1:0] AFULL_CNT = PW'(AFULL_LVL);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    cnt_d;
    logic             afull_q, afull_d;
    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] head;
    logic             full, empty, push, pop, drop;

    // Status is derived from registered pointers only, so in_ready never
    // depends combinationally on out_ready: a full queue refuses a push even
    // when the head is popped in the same cycle.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign drop  = q.flush | q.br_kill;
    assign push  = q.in_valid & ~full;
    assign pop   = q.out_ready & ~empty;

    // Next-state pointers: a flush/kill discards everything, including any
    // same-cycle push; otherwise push and pop advance independently.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (drop) begin
            wr_ptr_d = rd_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q + PW'(push);
            rd_ptr_d = rd_ptr_q + PW'(pop);
        end
        cnt_d   = wr_ptr_d - rd_ptr_d;
        afull_d = (cnt_d >= AFULL_CNT);
    end

    // Pointer and almost-full registers; afull comes from next-state count so
    // it lines up with the count visible in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            afull_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            afull_q  <= afull_d;
        end
    end

    // Entry storage; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (push && !drop) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {q.in_exc, q.in_pc, q.in_inst};
        end
    end

    // Head entry read straight from storage and zeroed when the queue is empty,
    // so the decoder sees a nop rather than stale data.
    assign head       = mem_q[rd_ptr_q[AW-1:0]];
    assign q.out_inst = empty ? '0 : head[INST_W-1:0];
    assign q.out_pc   = empty ? '0 : head[INST_W +: PC_W];
    assign q.out_exc  = empty ? '0 : head[INST_W+PC_W +: EXC_W];

    assign q.out_valid = ~empty;
    assign q.in_ready  = ~full;
    assign q.count     = wr_ptr_q - rd_ptr_q;
    assign q.afull     = afull_q;
endmodule

// File: tb/tb_id_inst_queue.sv
// Bench for id_inst_queue (DEPTH=4): a vector table covering fill, full-with-pop,
// drain, concurrent push/pop across wrap, branch-kill, flush and exception payload,
// then a random phase whose expectations come from the scoreboard queue, then a
// mid-stream reset. Popped entries are checked against the scoreboard.
module tb_id_inst_queue;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_inst_queue_if #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32), .EXC_W(32)) q ();

    id_inst_queue #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32), .EXC_W(32), .AFULL_LVL(DEPTH-1)) dut (
        .clk (clk),
        .rst (rst),
        .q   (q.slave)
    );

    typedef struct {
        logic        fl, bk, iv;
        logic [31:0] pc, exc;
        logic        ordy;
        int          cnt;
        logic        irdy, af, ov;
        logic [31:0] opc, oexc;
    } vec_t;

    typedef struct {
        logic [31:0] pc, inst, exc;
    } ent_t;

    vec_t tbl[$];
    ent_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hDEAD_0000;
    endfunction

    function automatic vec_t mk(input logic fl, bk, iv, input logic [31:0] pc, exc,
                                input logic ordy, input int cnt,
                                input logic irdy, af, ov, input logic [31:0] opc, oexc);
        vec_t v;
        v.fl = fl; v.bk = bk; v.iv = iv; v.pc = pc; v.exc = exc; v.ordy = ordy;
        v.cnt = cnt; v.irdy = irdy; v.af = af; v.ov = ov; v.opc = opc; v.oexc = oexc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle, check pre-edge outputs, update the scoreboard, clock.
    task automatic apply(input vec_t v, input int idx);
        ent_t e;
        q.flush = v.fl; q.br_kill = v.bk; q.in_valid = v.iv;
        q.in_pc = v.pc; q.in_inst = inst_of(v.pc); q.in_exc = v.exc;
        q.out_ready = v.ordy;
        #1;
        chk("count",     32'(q.count), 32'(v.cnt));
        chk("in_ready",  32'(q.in_ready), 32'(v.irdy));
        chk("afull",     32'(q.afull), 32'(v.af));
        chk("out_valid", 32'(q.out_valid), 32'(v.ov));
        chk("out_pc",    q.out_pc, v.opc);
        chk("out_exc",   q.out_exc, v.oexc);
        if (!v.ov) chk("out_inst_zero", q.out_inst, 32'h0);
        if (v.fl || v.bk) begin
            sb.delete();
        end else begin
            if (v.ov && v.ordy) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL sb_underflow: vector %0d popped with empty scoreboard", idx);
                end else begin
                    e = sb.pop_front();
                    chk("pop_pc",   q.out_pc, e.pc);
                    chk("pop_inst", q.out_inst, e.inst);
                    chk("pop_exc",  q.out_exc, e.exc);
                end
            end
            if (v.iv && v.irdy) begin
                e.pc = v.pc; e.inst = inst_of(v.pc); e.exc = v.exc;
                sb.push_back(e);
            end
        end
        $display("vec %0d: fl=%0b bk=%0b iv=%0b pc=%h ordy=%0b | cnt=%0d ov=%0b opc=%h",
                 idx, v.fl, v.bk, v.iv, v.pc, v.ordy, q.count, q.out_valid, q.out_pc);
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t model_vec(input logic fl, bk, iv, input logic [31:0] pc, exc,
                                       input logic ordy);
        int n = sb.size();
        return mk(fl, bk, iv, pc, exc, ordy, n, n < DEPTH, n >= DEPTH-1, n > 0,
                  (n > 0) ? sb[0].pc : 32'h0, (n > 0) ? sb[0].exc : 32'h0);
    endfunction

    initial begin
        q.flush = 0; q.br_kill = 0; q.in_valid = 0; q.in_pc = '0; q.in_inst = '0;
        q.in_exc = '0; q.out_ready = 0;

        //            fl bk iv pc          exc           ordy cnt irdy af ov opc         oexc
        // fill
        tbl.push_back(mk(0,0,1,32'h100,32'h0,0, 0,1,0,0,32'h0,  32'h0));
        tbl.push_back(mk(0,0,1,32'h104,32'h0,0, 1,1,0,1,32'h100,32'h0));
        tbl.push_back(mk(0,0,1,32'h108,32'h0,0, 2,1,0,1,32'h100,32'h0));
        tbl.push_back(mk(0,0,1,32'h10C,32'h0,0, 3,1,1,1,32'h100,32'h0));
        tbl.push_back(mk(0,0,0,32'h0,  32'h0,0, 4,0,1,1,32'h100,32'h0));
        // full with pop: push refused, pop happens
        tbl.push_back(mk(0,0,1,32'h1FC,32'h0,1, 4,0,1,1,32'h100,32'h0));
        tbl.push_back(mk(0,0,0,32'h0,  32'h0,0, 3,1,1,1,32'h104,32'h0));
        // drain
        tbl.push_back(mk(0,0,0,32'h0,  32'h0,1, 3,1,1,1,32'h104,32'h0));
        tbl.push_back(mk(0,0,0,32'h0,  32'h0,1, 2,1,0,1,32'h108,32'h0));
        tbl.push_back(mk(0,0,0,32'h0,  32'h0,1, 1,1,0,1,32'h10C,32'h0));
        tbl.push_back(mk(0,0,0,32'h0,  32'h0,1, 0,1,0,0,32'h0,  32'h0));
        // empty with push and out_ready: no bypass
        tbl.push_back(mk(0,0,1,32'h200,32'h0,1, 0,1,0,0,32'h0,  32'h0));
        tbl.push_back(mk(0,0,1,32'h204,32'h0,0, 1,1,0,1,32'h200,32'h0));
        // concurrent push/pop at count 2, across pointer wrap
        tbl.push_back(mk(0,0,1,32'h208,32'h0,1, 2,1,0,1,32'h200,32'h0));
        tbl.push_back(mk(0,0,1,32'h20C,32'h0,1, 2,1,0,1,32'h204,32'h0));
        tbl.push_back(mk(0,0,1,32'h210,32'h0,1, 2,1,0,1,32'h208,32'h0));
        tbl.push_back(mk(0,0,1,32'h214,32'h0,1, 2,1,0,1,32'h20C,32'h0));
        tbl.push_back(mk(0,0,1,32'h218,32'h0,1, 2,1,0,1,32'h210,32'h0));
        tbl.push_back(mk(0,0,1,32'h21C,32'h0,1, 2,1,0,1,32'h214,32'h0));
        tbl.push_back(mk(0,0,0,32'h0,  32'h0,0, 2,1,0,1,32'h218,32'h0));
        // br_kill at count 3 with a same-cycle push and pop
        tbl.push_back(mk(0,0,1,32'h220,32'h0,0, 2,1,0,1,32'h218,32'h0));
        tbl.push_back(mk(0,0,0,32'h0,  32'h0,0, 3,1,1,1,32'h218,32'h0));
        tbl.push_back(mk(0,1,1,32'h300,32'h0,1, 3,1,1,1,32'h218,32'h0));
        tbl.push_back(mk(0,0,0,32'h0,  32'h0,0, 0,1,0,0,32'h0,  32'h0));
        tbl.push_back(mk(0,0,1,32'h304,32'h0,0, 0,1,0,0,32'h0,  32'h0));
        // flush at count 3 with a same-cycle push
        tbl.push_back(mk(0,0,1,32'h308,32'h0,0, 1,1,0,1,32'h304,32'h0));
        tbl.push_back(mk(0,0,1,32'h30C,32'h0,0, 2,1,0,1,32'h304,32'h0));
        tbl.push_back(mk(1,0,1,32'h310,32'h0,0, 3,1,1,1,32'h304,32'h0));
        tbl.push_back(mk(0,0,0,32'h0,  32'h0,0, 0,1,0,0,32'h0,  32'h0));
        // exception payload
        tbl.push_back(mk(0,0,1,32'h400,32'h0001_0000,0, 0,1,0,0,32'h0,  32'h0));
        tbl.push_back(mk(0,0,1,32'h404,32'h0,        0, 1,1,0,1,32'h400,32'h0001_0000));
        tbl.push_back(mk(0,0,1,32'h408,32'h0,        0, 2,1,0,1,32'h400,32'h0001_0000));
        tbl.push_back(mk(0,0,0,32'h0,  32'h0,        1, 3,1,1,1,32'h400,32'h0001_0000));
        tbl.push_back(mk(0,0,0,32'h0,  32'h0,        0, 2,1,0,1,32'h404,32'h0));

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count",     32'(q.count), 32'h0);
        chk("rst_in_ready",  32'(q.in_ready), 32'h1);
        chk("rst_afull",     32'(q.afull), 32'h0);
        chk("rst_out_valid", 32'(q.out_valid), 32'h0);
        chk("rst_out_pc",    q.out_pc, 32'h0);
        rst = 1'b0;

        foreach (tbl[i]) apply(tbl[i], i);

        // random traffic, expectations from the scoreboard occupancy
        for (int i = 0; i < 300; i++) begin
            logic fl = ($urandom_range(0, 24) == 0);
            logic bk = ($urandom_range(0, 24) == 0);
            apply(model_vec(fl, bk, 1'($urandom_range(0, 2) != 0), $urandom, $urandom,
                            1'($urandom_range(0, 1))), 1000 + i);
        end

        // mid-stream reset: fill two entries, then reset with a push pending
        if (sb.size() != 0) apply(model_vec(1, 0, 0, 32'h0, 32'h0, 0), 2000);
        apply(model_vec(0, 0, 1, 32'h500, 32'h5, 0), 2001);
        apply(model_vec(0, 0, 1, 32'h504, 32'h6, 0), 2002);
        rst = 1'b1;
        q.in_valid = 1'b1; q.in_pc = 32'h508; q.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_count",     32'(q.count), 32'h0);
        chk("midrst_out_valid", 32'(q.out_valid), 32'h0);
        chk("midrst_out_pc",    q.out_pc, 32'h0);
        chk("midrst_out_inst",  q.out_inst, 32'h0);
        chk("midrst_out_exc",   q.out_exc, 32'h0);
        chk("midrst_in_ready",  32'(q.in_ready), 32'h1);
        chk("midrst_afull",     32'(q.afull), 32'h0);
        $display("midstream reset: count=%0d out_valid=%0b", q.count, q.out_valid);
        rst = 1'b0;
        sb.delete();
        q.in_valid = 1'b0; q.out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
